// File: rtl/instr_pkg.sv
// Shared instruction encoding: class codes, opcodes and encoder states.
// The control decoder imports the same package so both sides stay aligned.
package instr_pkg;

    typedef enum logic [3:0] {
        CL_R     = 4'd0,
        CL_BEQ   = 4'd1,
        CL_SRL   = 4'd2,
        CL_SLL   = 4'd3,
        CL_LOAD  = 4'd4,
        CL_STORE = 4'd5,
        CL_JUMP  = 4'd6,
        CL_IMM   = 4'd7,
        CL_SWAP  = 4'd8
    } instr_class_e;

    localparam logic [2:0] OP_R     = 3'b000;
    localparam logic [2:0] OP_BEQ   = 3'b001;
    localparam logic [2:0] OP_SRL   = 3'b010;
    localparam logic [2:0] OP_SLL   = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_JUMP  = 3'b110;
    localparam logic [2:0] OP_ITYPE = 3'b111;

    localparam logic [1:0] FUNC_SWAP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic       legal;
        logic [8:0] word;
    } enc_t;

    // IMM and SWAP share OP_ITYPE; the low operand bits tell them apart.
    function automatic enc_t encode(input logic [3:0] cls, input logic [5:0] opd);
        enc_t r;
        r.legal = 1'b1;
        r.word  = {OP_R, opd};
        case (cls)
            CL_R:     r.word = {OP_R, opd};
            CL_BEQ:   r.word = {OP_BEQ, opd};
            CL_SRL:   r.word = {OP_SRL, opd};
            CL_SLL:   r.word = {OP_SLL, opd};
            CL_LOAD:  r.word = {OP_LOAD, opd};
            CL_STORE: r.word = {OP_STORE, opd};
            CL_JUMP:  r.word = {OP_JUMP, opd};
            CL_IMM: begin
                r.word  = {OP_ITYPE, opd};
                r.legal = (opd[1:0] != FUNC_SWAP);
            end
            CL_SWAP:  r.word = {OP_ITYPE, opd[5:2], FUNC_SWAP};
            default:  r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request side and instruction-memory write side of the encoder.
// master = program loader / memory model, slave = encoder.
interface instr_encoder_if #(parameter int AW = 8);
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_class;
    logic [5:0]    in_operand;
    logic          in_last;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [8:0]    wr_data;

    modport master (
        output in_valid, in_class, in_operand, in_last,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_class, in_operand, in_last,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_encoder_fifo.sv
// Synchronous DEPTH x W FIFO with flush; flush wins over push/pop.
// Latency: pushed word visible on dout the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign dout  = mem_q[rd_ptr_q[PW-1:0]];
    assign do_push = push && !full && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push)
                wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
            if (pop && !empty)
                rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q[PW-1:0]] <= din;
    end
endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic instructions into 9-bit words and writes them to consecutive addresses.
// Latency: word accepted at edge N is strobed on wr_en after edge N+1; 1 word/cycle sustained.
// Backpressure: in_ready drops when FIFO full, outside LOAD, on start, or after overflow.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    instr_encoder_if.slave   bus,
    output logic             done,
    output logic             err,
    output logic             ovf
);
    state_e        state_q, state_d;
    logic [AW:0]   addr_q, addr_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [8:0]    wr_data_q, wr_data_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;

    enc_t          enc;
    logic          in_ready_w, accept, push, pop, flush, active, exhausted;
    logic          full, empty;
    logic [8:0]    fifo_dout;

    // addr_q carries one extra bit so a wrap past the top address is visible.
    assign exhausted  = addr_q[AW];
    assign active     = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign in_ready_w = (state_q == ST_LOAD) && !full && !ovf_q && !start;
    assign accept     = bus.in_valid && in_ready_w;
    assign enc        = encode(bus.in_class, bus.in_operand);
    assign push       = accept && enc.legal;
    assign pop        = active && !empty && !exhausted && !start;
    assign flush      = start || (active && exhausted);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                if (start)                       state_d = ST_LOAD;
                else if (exhausted)              state_d = ST_DONE;
                else if (accept && bus.in_last)  state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (start)                       state_d = ST_LOAD;
                else if (exhausted || empty)     state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (start) begin
            addr_d = '0;
        end else if (pop) begin
            addr_d    = addr_q + {{AW{1'b0}}, 1'b1};
            wr_addr_d = addr_q[AW-1:0];
            wr_data_d = fifo_dout;
        end
        wr_en_d = pop;
        err_d   = accept && !enc.legal;
        ovf_d   = start ? 1'b0 : (ovf_q || (active && exhausted));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    enc_fifo #(.DEPTH(DEPTH), .W(9)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (enc.word),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign bus.in_ready = in_ready_w;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign done         = (state_q == ST_DONE);
    assign err          = err_q;
    assign ovf          = ovf_q;
endmodule
